// File: rtl/inst_mem_loader.sv
// inst_mem_loader: loads a framed, XOR-checked byte stream into instruction memory and holds the core in reset until it verifies.
module inst_mem_loader #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int IW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_start,
  input  logic [7:0]    byte_in,
  input  logic          byte_valid,
  output logic          byte_ready,
  input  logic [AW-1:0] fetch_addr,
  output logic [IW-1:0] fetch_data,
  output logic          core_rst,
  output logic          load_done,
  output logic          load_err,
  output logic [AW:0]   words_loaded
);
  typedef enum logic [2:0] {IDLE, LEN, DATA, CSUM, DONE, ERR} state_t;
  state_t state, nxt;
  logic [IW-1:0] mem [DEPTH];
  logic [AW:0] n;
  logic [1:0] byte_idx;
  logic [AW-1:0] word_idx;
  logic [7:0] csum;
  logic [23:0] shreg;
  logic acc, word_end, last_word, len_bad;
  logic nxt_ready, nxt_core_rst, nxt_done, nxt_err;
  assign acc = byte_valid && byte_ready;
  assign word_end = byte_idx == 2'd3;
  assign last_word = {1'b0, word_idx} == n - (AW+1)'(1);
  assign len_bad = byte_in == 8'd0 || byte_in > 8'(DEPTH);
  assign fetch_data = mem[fetch_addr];
  always_ff @(posedge clk)
    state <= rst ? IDLE : nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = load_start ? LEN : IDLE;
      LEN:     nxt = acc ? (len_bad ? ERR : DATA) : LEN;
      DATA:    nxt = acc && word_end && last_word ? CSUM : DATA;
      CSUM:    nxt = acc ? (byte_in == csum ? DONE : ERR) : CSUM;
      DONE:    nxt = load_start ? LEN : DONE;
      ERR:     nxt = load_start ? LEN : ERR;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    nxt_ready = nxt == LEN || nxt == DATA || nxt == CSUM;
    nxt_done = nxt == DONE;
    nxt_err = nxt == ERR;
    nxt_core_rst = nxt != DONE;
  end
  always_ff @(posedge clk) begin
    byte_ready <= rst ? 1'b0 : nxt_ready;
    load_done <= rst ? 1'b0 : nxt_done;
    load_err <= rst ? 1'b0 : nxt_err;
    core_rst <= rst ? 1'b1 : nxt_core_rst;
  end
  // Every length byte, legal or not, starts a fresh load with zeroed counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      n <= '0;
      byte_idx <= '0;
      word_idx <= '0;
      csum <= '0;
      shreg <= '0;
      words_loaded <= '0;
    end else if (acc && state == LEN) begin
      n <= byte_in[AW:0];
      byte_idx <= '0;
      word_idx <= '0;
      csum <= '0;
      words_loaded <= '0;
    end else if (acc && state == DATA) begin
      csum <= csum ^ byte_in;
      shreg <= {shreg[15:0], byte_in};
      byte_idx <= byte_idx + 2'd1;
      if (word_end) begin
        word_idx <= word_idx + AW'(1);
        words_loaded <= words_loaded + (AW+1)'(1);
      end
    end
  end
  always_ff @(posedge clk)
    if (!rst && acc && state == DATA && word_end) mem[word_idx] <= {shreg, byte_in};
endmodule

// File: tb/tb_inst_mem_loader.sv
// tb_inst_mem_loader: table vectors, corner sequences and random frames against a frame-level reference model.
module tb_inst_mem_loader;
  logic clk = 0;
  logic rst, load_start, byte_valid, byte_ready, core_rst, load_done, load_err;
  logic [7:0] byte_in;
  logic [3:0] fetch_addr;
  logic [31:0] fetch_data;
  logic [4:0] words_loaded;
  int errors = 0, checks = 0;
  logic [31:0] frame_w [16];
  logic [31:0] model_mem [16];
  bit known [16];
  logic exp_done, exp_err;
  logic [4:0] exp_words;
  int pulse_idx = -1, mingap = 0, maxgap = 0;

  typedef struct {
    int n;
    logic [31:0] w0, w1;
    logic [7:0] cs;
    logic done, err;
    logic [4:0] words;
    logic [31:0] m0, m1;
  } vec_t;
  vec_t tbl [5];

  inst_mem_loader dut (
    .clk(clk), .rst(rst), .load_start(load_start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .fetch_addr(fetch_addr),
    .fetch_data(fetch_data), .core_rst(core_rst), .load_done(load_done),
    .load_err(load_err), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  task chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] xsum(input int n);
    logic [7:0] x = 0;
    for (int i = 0; i < n; i++) x ^= frame_w[i][31:24] ^ frame_w[i][23:16] ^ frame_w[i][15:8] ^ frame_w[i][7:0];
    return x;
  endfunction

  task send(input logic [7:0] b);
    int k;
    repeat ($urandom_range(mingap, maxgap)) @(negedge clk);
    byte_valid = 1;
    byte_in = b;
    k = 0;
    while (!byte_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (!byte_ready) begin
      errors++;
      $display("FAIL byte_ready_wait: got 0 expected 1");
    end else begin
      @(posedge clk);
      #1;
    end
    byte_valid = 0;
  endtask

  task start_load();
    @(negedge clk);
    load_start = 1;
    @(posedge clk);
    #1;
    load_start = 0;
    chk("start.byte_ready", byte_ready, 1);
  endtask

  task run_frame(input int n, input logic [7:0] cs);
    bit legal;
    legal = n >= 1 && n <= 16;
    start_load();
    send(8'(n));
    if (legal) begin
      for (int i = 0; i < n; i++) begin
        for (int k = 0; k < 4; k++) begin
          if (i * 4 + k == pulse_idx) begin
            @(negedge clk);
            load_start = 1;
            @(negedge clk);
            load_start = 0;
          end
          send(frame_w[i][31-8*k -: 8]);
        end
        model_mem[i] = frame_w[i];
        known[i] = 1;
      end
      send(cs);
    end
    exp_done = legal && cs == xsum(n);
    exp_err = !exp_done;
    exp_words = legal ? 5'(n) : 5'd0;
  endtask

  task check_all(input string tag);
    chk({tag, ".done"}, load_done, exp_done);
    chk({tag, ".err"}, load_err, exp_err);
    chk({tag, ".core_rst"}, core_rst, !exp_done);
    chk({tag, ".words"}, words_loaded, exp_words);
    chk({tag, ".byte_ready"}, byte_ready, 0);
    for (int i = 0; i < 16; i++)
      if (known[i]) begin
        fetch_addr = 4'(i);
        #1;
        chk({tag, ".mem"}, fetch_data, model_mem[i]);
      end
  endtask

  task do_reset();
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    exp_done = 0;
    exp_err = 0;
    exp_words = 0;
  endtask

  initial begin
    tbl[0] = '{2, 32'h08400005, 32'h10820003, 8'hDC, 1, 0, 5'd2, 32'h08400005, 32'h10820003};
    tbl[1] = '{2, 32'h08400005, 32'h10820003, 8'hDD, 0, 1, 5'd2, 32'h08400005, 32'h10820003};
    tbl[2] = '{0, 32'h0, 32'h0, 8'h00, 0, 1, 5'd0, 32'h08400005, 32'h10820003};
    tbl[3] = '{17, 32'h0, 32'h0, 8'h00, 0, 1, 5'd0, 32'h08400005, 32'h10820003};
    tbl[4] = '{1, 32'hDEADBEEF, 32'h0, 8'h22, 1, 0, 5'd1, 32'hDEADBEEF, 32'h10820003};
    rst = 1; load_start = 0; byte_valid = 0; byte_in = 0; fetch_addr = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.byte_ready", byte_ready, 0);
    chk("reset.core_rst", core_rst, 1);
    chk("reset.done", load_done, 0);
    chk("reset.err", load_err, 0);
    chk("reset.words", words_loaded, 0);
    rst = 0;

    foreach (tbl[v]) begin
      frame_w[0] = tbl[v].w0;
      frame_w[1] = tbl[v].w1;
      run_frame(tbl[v].n, tbl[v].cs);
      chk("tbl.done", load_done, tbl[v].done);
      chk("tbl.err", load_err, tbl[v].err);
      chk("tbl.core_rst", core_rst, !tbl[v].done);
      chk("tbl.words", words_loaded, tbl[v].words);
      chk("tbl.byte_ready", byte_ready, 0);
      fetch_addr = 0;
      #1;
      chk("tbl.mem0", fetch_data, tbl[v].m0);
      fetch_addr = 1;
      #1;
      chk("tbl.mem1", fetch_data, tbl[v].m1);
    end

    frame_w[0] = 32'h08400005;
    frame_w[1] = 32'h10820003;
    mingap = 1;
    maxgap = 3;
    run_frame(2, 8'hDC);
    check_all("gapped");
    mingap = 0;
    maxgap = 0;

    start_load();
    send(8'h02); send(8'h08); send(8'h40); send(8'h00); send(8'h05); send(8'h10);
    do_reset();
    chk("midrst.byte_ready", byte_ready, 0);
    chk("midrst.core_rst", core_rst, 1);
    chk("midrst.done", load_done, 0);
    chk("midrst.err", load_err, 0);
    chk("midrst.words", words_loaded, 0);
    fetch_addr = 0;
    #1;
    chk("midrst.mem0", fetch_data, 32'h08400005);
    run_frame(2, 8'hDC);
    check_all("midrst.reload");

    for (int i = 0; i < 16; i++) frame_w[i] = 32'(i);
    pulse_idx = 21;
    run_frame(16, 8'h00);
    pulse_idx = -1;
    check_all("full");
    fetch_addr = 15;
    #1;
    chk("full.mem15", fetch_data, 32'h0000000F);
    chk("full.words", words_loaded, 16);
    @(negedge clk);
    load_start = 1;
    @(posedge clk);
    #1;
    load_start = 0;
    chk("restart.core_rst", core_rst, 1);
    chk("restart.done", load_done, 0);
    chk("restart.byte_ready", byte_ready, 1);
    do_reset();

    maxgap = 2;
    for (int t = 0; t < 40; t++) begin
      int n;
      logic [7:0] cs;
      n = $urandom_range(0, 17);
      for (int i = 0; i < 16; i++) frame_w[i] = $urandom;
      cs = xsum(n);
      if ($urandom_range(0, 3) == 0) cs ^= 8'($urandom_range(1, 255));
      run_frame(n, cs);
      check_all("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
